// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU and load unit share one write port, round-robin on conflict.
// Optional forwarding from the write stage is compiled in with RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  localparam int unsigned AW     = 5,
  localparam int unsigned DW     = 32,
  localparam int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_rd,
  input  logic [DW-1:0]    alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [AW-1:0]    mem_rd,
  input  logic [DW-1:0]    mem_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_a3,
  output logic [DW-1:0]    rf_wd,
  output logic [CNT_W-1:0] conflict_cnt
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]    byp_a1,
  input  logic [AW-1:0]    byp_a2,
  output logic             byp_hit1,
  output logic             byp_hit2,
  output logic [DW-1:0]    byp_data1,
  output logic [DW-1:0]    byp_data2
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
  } wb_t;

  pri_e          pri_q;
  pri_e          pri_d;
  wb_t           wb_q;
  logic          grant;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;
  logic [CNT_W-1:0] cnt_q;

  // Priority state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri_q <= PRI_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Grant selection and priority update; nothing is granted while in reset.
  always_comb begin
    pri_d     = pri_q;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    sel_rd    = alu_rd;
    sel_data  = alu_data;
    if (rst_n) begin
      if (alu_valid && (!mem_valid || (pri_q == PRI_ALU))) begin
        alu_ready = 1'b1;
        pri_d     = PRI_MEM;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
        sel_rd    = mem_rd;
        sel_data  = mem_data;
        pri_d     = PRI_ALU;
      end
    end
  end

  assign grant = alu_ready | mem_ready;

  // Write stage: x0 writes are accepted but never enable the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q.we <= grant && (sel_rd != '0);
      if (grant) begin
        wb_q.a3 <= sel_rd;
        wb_q.wd <= sel_data;
      end
    end
  end

  // Saturating count of contended cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (alu_valid && mem_valid && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rf_we        = wb_q.we;
  assign rf_a3        = wb_q.a3;
  assign rf_wd        = wb_q.wd;
  assign conflict_cnt = cnt_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the in-flight write to readers of the same register.
  assign byp_hit1  = wb_q.we && (byp_a1 == wb_q.a3);
  assign byp_hit2  = wb_q.we && (byp_a2 == wb_q.a3);
  assign byp_data1 = byp_hit1 ? wb_q.wd : '0;
  assign byp_data2 = byp_hit2 ? wb_q.wd : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the arbitration rules.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [15:0] conflict_cnt;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  byp_a1, byp_a2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .conflict_cnt(conflict_cnt)
`ifdef RF_WB_BYPASS_EN
    , .byp_a1(byp_a1), .byp_a2(byp_a2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: what the register-file port and counter must show, plus whose turn a tie is.
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          m_cnt;
  bit          m_alu_turn;
  bit          last_ga, last_gm;
  logic        s_alu_ready, s_mem_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance the model at the edge.
  task automatic tick();
    bit ga, gm;
    @(negedge clk);
    ga = (rst_n === 1'b1) && alu_valid && (!mem_valid || m_alu_turn);
    gm = (rst_n === 1'b1) && mem_valid && !ga;
    s_alu_ready = alu_ready;
    s_mem_ready = mem_ready;
    chk("alu_ready", 32'(alu_ready), 32'(ga));
    chk("mem_ready", 32'(mem_ready), 32'(gm));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_a3", 32'(rf_a3), 32'(m_a3));
    chk("rf_wd", rf_wd, m_wd);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`ifdef RF_WB_BYPASS_EN
    chk("byp_hit1", 32'(byp_hit1), 32'(m_we && byp_a1 == m_a3));
    chk("byp_hit2", 32'(byp_hit2), 32'(m_we && byp_a2 == m_a3));
    chk("byp_data1", byp_data1, (m_we && byp_a1 == m_a3) ? m_wd : 32'h0);
    chk("byp_data2", byp_data2, (m_we && byp_a2 == m_a3) ? m_wd : 32'h0);
`endif
    @(posedge clk);
    #1;
    if (rst_n !== 1'b1) begin
      m_we = 1'b0; m_a3 = '0; m_wd = '0; m_cnt = 0; m_alu_turn = 1'b1;
    end else begin
      if (alu_valid && mem_valid && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (ga) begin
        m_we = (alu_rd != 0); m_a3 = alu_rd; m_wd = alu_data; m_alu_turn = 1'b0;
      end else if (gm) begin
        m_we = (mem_rd != 0); m_a3 = mem_rd; m_wd = mem_data; m_alu_turn = 1'b1;
      end else begin
        m_we = 1'b0;
      end
    end
    last_ga = ga;
    last_gm = gm;
  endtask

  task automatic set_req(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  function automatic logic [4:0] rand_rd();
    return ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  initial begin
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
`ifdef RF_WB_BYPASS_EN
    byp_a1 = '0; byp_a2 = '0;
`endif
    m_we = 1'b0; m_a3 = '0; m_wd = '0; m_cnt = 0; m_alu_turn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset: readys held low even with requests pending.
    set_req(1, 5'd9, 32'h9, 1, 5'd10, 32'hA);
    tick();
    chk("rst_alu_ready", 32'(s_alu_ready), 32'h0);
    chk("rst_mem_ready", 32'(s_mem_ready), 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_rf_a3", 32'(rf_a3), 32'h0);
    chk("rst_rf_wd", rf_wd, 32'h0);
    chk("rst_cnt", 32'(conflict_cnt), 32'h0);

    // ALU only.
    rst_n = 1'b1;
    set_req(1, 5'd5, 32'h11111111, 0, 0, 0);
    tick();
    chk("alu_only_ready", 32'(s_alu_ready), 32'h1);
    chk("alu_only_we", 32'(rf_we), 32'h1);
    chk("alu_only_a3", 32'(rf_a3), 32'd5);
    chk("alu_only_wd", rf_wd, 32'h11111111);

    // Round-robin from reset: ALU, MEM, ALU, MEM.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(1, 5'd1, 32'hAAAA0001, 1, 5'd2, 32'hBBBB0002);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_alu_grant", 32'(s_alu_ready), 32'((i % 2) == 0));
      chk("rr_mem_grant", 32'(s_mem_ready), 32'((i % 2) == 1));
    end
    chk("rr_last_a3", 32'(rf_a3), 32'd2);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    chk("rr_cnt", 32'(conflict_cnt), 32'd4);

    // Load to x0: accepted, no write enable, address still updates.
    set_req(0, 0, 0, 1, 5'd0, 32'hDEADBEEF);
    tick();
    chk("x0_ready", 32'(s_mem_ready), 32'h1);
    chk("x0_we", 32'(rf_we), 32'h0);
    chk("x0_a3", 32'(rf_a3), 32'h0);

`ifdef RF_WB_BYPASS_EN
    // Forwarding on the write cycle.
    set_req(1, 5'd7, 32'h0000ABCD, 0, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    byp_a1 = 5'd7; byp_a2 = 5'd8;
    #1;
    chk("byp_hit1_lit", 32'(byp_hit1), 32'h1);
    chk("byp_data1_lit", byp_data1, 32'h0000ABCD);
    chk("byp_hit2_lit", 32'(byp_hit2), 32'h0);
    chk("byp_data2_lit", byp_data2, 32'h0);
    tick();
`endif

    // Grant then reset: pending write cancelled, priority back to ALU.
    set_req(0, 0, 0, 1, 5'd3, 32'h33333333);
    tick();
    chk("gr_mem_ready", 32'(s_mem_ready), 32'h1);
    rst_n = 1'b0;
    set_req(1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
    tick();
    chk("gr_rst_alu_ready", 32'(s_alu_ready), 32'h0);
    chk("gr_rst_mem_ready", 32'(s_mem_ready), 32'h0);
    chk("gr_rst_we", 32'(rf_we), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("gr_pri_alu", 32'(s_alu_ready), 32'h1);
    set_req(0, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic; a request stays put until granted.
    for (int i = 0; i < 3000; i++) begin
      if (!alu_valid || last_ga) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = rand_rd();
        alu_data  = $urandom;
      end
      if (!mem_valid || last_gm) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = rand_rd();
        mem_data  = $urandom;
      end
      rst_n = ($urandom_range(0, 40) != 0);
`ifdef RF_WB_BYPASS_EN
      byp_a1 = ($urandom_range(0, 1) != 0) ? m_a3 : 5'($urandom_range(0, 31));
      byp_a2 = 5'($urandom_range(0, 31));
`endif
      tick();
    end

    // Saturation of the conflict counter.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(1, 5'd11, 32'h1, 1, 5'd12, 32'h2);
    for (int i = 0; i < 65540; i++) tick();
    chk("sat_cnt", 32'(conflict_cnt), 32'h0000FFFF);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    chk("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
